// File: rtl/i8085_bus_pkg.sv
// Shared types and constants for the 8085 external-bus memory responder.
// Contents:
//   rsp_state_t  - responder FSM state encoding
//   IO_M_MEM/IO  - io_m pin values for memory and I/O cycles
//   MAX_WAIT     - largest wait-state count the 3-bit counter can hold
//   addr_hit()   - window decode used on the ale edge
package i8085_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_WAIT     = 3'd2,
        ST_RD_DRIVE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_ERR      = 3'd5
    } rsp_state_t;

    localparam logic IO_M_MEM = 1'b0;
    localparam logic IO_M_IO  = 1'b1;
    localparam int   MAX_WAIT = 7;

    // Memory cycle whose address lies in [base, base + 2**addr_w).
    // The subtraction is done in 17 bits so an address below base turns
    // into a huge positive delta instead of wrapping into the window.
    function automatic logic addr_hit(input logic [15:0] address,
                                      input logic        io_m,
                                      input logic [15:0] base,
                                      input int          addr_w);
        logic [16:0] delta;
        delta = {1'b0, address} - {1'b0, base};
        return (io_m == IO_M_MEM) && ({15'd0, delta} < (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// 8085 external-bus control/address bundle between the CPU side and a
// memory responder. The bidirectional DATA bus is not part of this bundle;
// it stays a pin-level inout on the responder so tri-state resolution
// happens on a real net.
//   master (CPU side):  drives ADDRESS, ale, io_m, rd_n, wr_n
//   slave  (responder): drives ready, busy, bus_err
interface memory_responder_if;

    logic [15:0] ADDRESS;
    logic        ale;
    logic        io_m;
    logic        rd_n;
    logic        wr_n;
    logic        ready;
    logic        busy;
    logic        bus_err;

    modport master (
        output ADDRESS, ale, io_m, rd_n, wr_n,
        input  ready, busy, bus_err
    );

    modport slave (
        input  ADDRESS, ale, io_m, rd_n, wr_n,
        output ready, busy, bus_err
    );

endinterface

// File: rtl/mem_array.sv
// Single-port byte RAM with synchronous write and registered read.
// Ports:
//   clk    - clock, all state on posedge
//   we     - write enable: mem[addr] <= wdata
//   re     - read enable: rdata <= mem[addr] (held otherwise)
//   addr   - byte address, ADDR_W bits
//   wdata  - write byte
//   rdata  - registered read byte
module mem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rdata_q;

    // NOTE: no reset on the array or its read register; contents are meant
    //       to survive rst, and a reset would stop this mapping onto a RAM.
    always_ff @(posedge clk) begin
        // NOTE: clocked state is assigned with <= so every flop samples the
        //       pre-edge values regardless of statement order.
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder on the 8085 external bus. Latches ADDRESS on ale,
// decodes a 2**ADDR_W byte window starting at BASE_ADDR, inserts
// WAIT_STATES cycles of ready=0, then either drives a read byte onto DATA
// or commits the DATA byte into the internal array.
// Ports:
//   clk   - clock, all state on posedge
//   rst   - synchronous reset, active-low
//   bus   - slave side of memory_responder_if (ADDRESS/ale/io_m/rd_n/wr_n
//           in; ready/busy/bus_err out)
//   DATA  - bidirectional data bus, driven only in RD_DRIVE while rd_n=0
module memory_responder
    import i8085_bus_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter logic [15:0] BASE_ADDR   = 16'h0100,
    parameter int          WAIT_STATES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    memory_responder_if.slave        bus,
    inout  wire  [7:0]               DATA
);

    // Clamp to what the 3-bit counter can represent.
    localparam int         WS        = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;
    // Counter is loaded with WS-1 and the data phase starts once it reads 0,
    // so WAIT lasts exactly WS cycles.
    localparam logic [2:0] WAIT_LOAD = (WS > 0) ? 3'(WS - 1) : 3'd0;

    rsp_state_t        state_q,    state_d;
    logic [ADDR_W-1:0] offset_q,   offset_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic              is_wr_q,    is_wr_d;
    logic              ready_q,    ready_d;
    logic              busy_q,     busy_d;
    logic              bus_err_q,  bus_err_d;
    logic              drive_q,    drive_d;

    logic              rd_low;
    logic              wr_low;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    assign rd_low = ~bus.rd_n;
    assign wr_low = ~bus.wr_n;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        //       skipped one would otherwise infer a latch.
        state_d    = state_q;
        offset_d   = offset_q;
        wait_cnt_d = wait_cnt_q;
        is_wr_d    = is_wr_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        if (bus.ale) begin
            // ale wins in every state: abandon whatever was in flight and
            // decode afresh. A miss leaves the cycle unowned.
            offset_d   = ADDR_W'(bus.ADDRESS - BASE_ADDR);
            wait_cnt_d = '0;
            is_wr_d    = 1'b0;
            state_d    = addr_hit(bus.ADDRESS, bus.io_m, BASE_ADDR, ADDR_W) ? ST_ADDR : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (rd_low && wr_low) begin
                        state_d = ST_ERR;
                    end else if (rd_low || wr_low) begin
                        is_wr_d = wr_low;
                        if (WS > 0) begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = WAIT_LOAD;
                        end else if (wr_low) begin
                            mem_we  = 1'b1;
                            state_d = ST_WR_HOLD;
                        end else begin
                            mem_re  = 1'b1;
                            state_d = ST_RD_DRIVE;
                        end
                    end
                end

                ST_WAIT: begin
                    if (rd_low && wr_low) begin
                        state_d = ST_ERR;
                    end else if (is_wr_q ? !wr_low : !rd_low) begin
                        // Strobe withdrawn before the data phase: no access.
                        state_d    = ST_IDLE;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q != 3'd0) begin
                        wait_cnt_d = wait_cnt_q - 3'd1;
                    end else if (is_wr_q) begin
                        mem_we  = 1'b1;
                        state_d = ST_WR_HOLD;
                    end else begin
                        mem_re  = 1'b1;
                        state_d = ST_RD_DRIVE;
                    end
                end

                ST_RD_DRIVE: begin
                    if (!rd_low) begin
                        state_d = ST_IDLE;
                    end
                end

                ST_WR_HOLD: begin
                    // One commit per cycle; just wait for the strobe to end.
                    if (!wr_low) begin
                        state_d = ST_IDLE;
                    end
                end

                ST_ERR: begin
                    if (!rd_low && !wr_low) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        bus_err_d = bus_err_q | (state_d == ST_ERR);
        ready_d   = (state_d != ST_WAIT);
        busy_d    = (state_d != ST_IDLE);
        drive_d   = (state_d == ST_RD_DRIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            offset_q   <= '0;
            wait_cnt_q <= '0;
            is_wr_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            bus_err_q  <= 1'b0;
            drive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            wait_cnt_q <= wait_cnt_d;
            is_wr_q    <= is_wr_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            bus_err_q  <= bus_err_d;
            drive_q    <= drive_d;
        end
    end

    // Array accesses are suppressed on a reset edge so a write that was
    // about to commit is discarded along with the rest of the cycle.
    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we & rst),
        .re    (mem_re & rst),
        .addr  (offset_q),
        .wdata (DATA),
        .rdata (mem_rdata)
    );

    // Release follows rd_n combinationally so the bus is freed as soon as
    // the CPU ends its read strobe.
    assign DATA = (drive_q && !bus.rd_n) ? mem_rdata : 8'bz;

    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder (ADDR_W=10, BASE_ADDR=0100h, WAIT_STATES=1).
// Read data goes through a scoreboard: each issued read pushes its expected
// byte, and a monitor pops and compares whenever the responder drives DATA.
// Status pins are compared inline with check().
module tb_memory_responder;
    import i8085_bus_pkg::*;

    localparam int WS = 1;

    logic       clk = 1'b0;
    logic       rst;
    wire  [7:0] data_bus;
    logic       tb_drive;
    logic [7:0] tb_data;
    logic       data_released;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    memory_responder_if bus_if ();

    assign data_bus      = tb_drive ? tb_data : 8'bz;
    assign data_released = (data_bus === 8'bz);

    memory_responder #(
        .ADDR_W      (10),
        .BASE_ADDR   (16'h0100),
        .WAIT_STATES (WS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .DATA (data_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns one negedge later with ale dropped.
    task automatic start_cycle(input logic [15:0] addr, input logic io);
        bus_if.ADDRESS = addr;
        bus_if.io_m    = io;
        bus_if.ale     = 1'b1;
        @(negedge clk);
        bus_if.ale     = 1'b0;
    endtask

    task automatic write_cycle(input logic [15:0] addr, input logic [7:0] data, input logic io,
                               output int low, output logic seen_busy);
        low       = 0;
        seen_busy = 1'b0;
        start_cycle(addr, io);
        bus_if.wr_n = 1'b0;
        tb_drive    = 1'b1;
        tb_data     = data;
        repeat (4) begin
            @(negedge clk);
            if (!bus_if.ready) low++;
            if (bus_if.busy) seen_busy = 1'b1;
        end
        bus_if.wr_n = 1'b1;
        tb_drive    = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_cycle(input logic [15:0] addr, input logic io, input logic hit,
                              input logic [7:0] exp, output int low, output logic seen_busy);
        low       = 0;
        seen_busy = 1'b0;
        if (hit) exp_q.push_back(exp);
        start_cycle(addr, io);
        bus_if.rd_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (!bus_if.ready) low++;
            if (bus_if.busy) seen_busy = 1'b1;
        end
        bus_if.rd_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: one comparison per contiguous stretch of responder drive.
    initial begin : monitor
        logic       seen;
        logic [7:0] e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!data_released && !tb_drive) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_drive: DATA=%h with no read pending (t=%0t)", data_bus, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", {24'd0, data_bus}, {24'd0, e});
                    end
                end
                seen = 1'b1;
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int   low;
        logic seen_busy;

        rst            = 1'b0;
        tb_drive       = 1'b0;
        tb_data        = 8'h00;
        bus_if.ADDRESS = 16'h0000;
        bus_if.ale     = 1'b0;
        bus_if.io_m    = IO_M_MEM;
        bus_if.rd_n    = 1'b1;
        bus_if.wr_n    = 1'b1;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        check("rst_ready",   32'(bus_if.ready),   1);
        check("rst_busy",    32'(bus_if.busy),    0);
        check("rst_bus_err", 32'(bus_if.bus_err), 0);
        check("rst_data_z",  32'(data_released),  1);
        rst = 1'b1;
        @(negedge clk);

        // Write then read back, including the first and last window bytes.
        write_cycle(16'h0105, 8'h5A, IO_M_MEM, low, seen_busy);
        check("wr_wait_cycles", 32'(low), WS);
        check("wr_busy",        32'(seen_busy), 1);
        check("wr_idle_after",  32'(bus_if.busy), 0);
        read_cycle(16'h0105, IO_M_MEM, 1'b1, 8'h5A, low, seen_busy);
        check("rd_wait_cycles", 32'(low), WS);
        check("rd_data_z_after", 32'(data_released), 1);
        write_cycle(16'h0100, 8'hA3, IO_M_MEM, low, seen_busy);
        write_cycle(16'h04FF, 8'h3C, IO_M_MEM, low, seen_busy);
        read_cycle(16'h04FF, IO_M_MEM, 1'b1, 8'h3C, low, seen_busy);
        read_cycle(16'h0100, IO_M_MEM, 1'b1, 8'hA3, low, seen_busy);

        // Misses just below and just above the window.
        read_cycle(16'h00FF, IO_M_MEM, 1'b0, 8'h00, low, seen_busy);
        check("miss_lo_busy",  32'(seen_busy), 0);
        check("miss_lo_ready", 32'(low), 0);
        read_cycle(16'h0500, IO_M_MEM, 1'b0, 8'h00, low, seen_busy);
        check("miss_hi_busy",  32'(seen_busy), 0);
        check("miss_hi_ready", 32'(low), 0);

        // I/O cycle to an in-window address is ignored.
        write_cycle(16'h0105, 8'hFF, IO_M_IO, low, seen_busy);
        check("io_busy",  32'(seen_busy), 0);
        check("io_ready", 32'(low), 0);
        read_cycle(16'h0105, IO_M_MEM, 1'b1, 8'h5A, low, seen_busy);

        // Both strobes low in an owned cycle.
        start_cycle(16'h0105, IO_M_MEM);
        bus_if.rd_n = 1'b0;
        bus_if.wr_n = 1'b0;
        @(negedge clk);
        check("conf_bus_err", 32'(bus_if.bus_err), 1);
        check("conf_busy",    32'(bus_if.busy),    1);
        check("conf_ready",   32'(bus_if.ready),   1);
        check("conf_data_z",  32'(data_released),  1);
        bus_if.rd_n = 1'b1;
        bus_if.wr_n = 1'b1;
        @(negedge clk);
        check("conf_idle",   32'(bus_if.busy),    0);
        check("conf_sticky", 32'(bus_if.bus_err), 1);
        read_cycle(16'h0105, IO_M_MEM, 1'b1, 8'h5A, low, seen_busy);
        check("conf_sticky2", 32'(bus_if.bus_err), 1);

        // Read strobe withdrawn during WAIT.
        start_cycle(16'h0100, IO_M_MEM);
        bus_if.rd_n = 1'b0;
        @(negedge clk);
        check("abort_rd_in_wait", 32'(bus_if.ready), 0);
        bus_if.rd_n = 1'b1;
        @(negedge clk);
        check("abort_rd_ready", 32'(bus_if.ready), 1);
        check("abort_rd_busy",  32'(bus_if.busy),  0);

        // Write strobe withdrawn during WAIT: nothing committed.
        start_cycle(16'h0100, IO_M_MEM);
        bus_if.wr_n = 1'b0;
        tb_drive    = 1'b1;
        tb_data     = 8'h77;
        @(negedge clk);
        check("abort_wr_in_wait", 32'(bus_if.ready), 0);
        bus_if.wr_n = 1'b1;
        tb_drive    = 1'b0;
        @(negedge clk);
        check("abort_wr_busy", 32'(bus_if.busy), 0);
        read_cycle(16'h0100, IO_M_MEM, 1'b1, 8'hA3, low, seen_busy);

        // ale during WAIT relatches; later ADDRESS changes are ignored.
        start_cycle(16'h0100, IO_M_MEM);
        bus_if.wr_n = 1'b0;
        tb_drive    = 1'b1;
        tb_data     = 8'h55;
        @(negedge clk);
        bus_if.wr_n    = 1'b1;
        tb_drive       = 1'b0;
        bus_if.ADDRESS = 16'h0105;
        bus_if.ale     = 1'b1;
        @(negedge clk);
        bus_if.ale = 1'b0;
        check("relatch_busy",  32'(bus_if.busy),  1);
        check("relatch_ready", 32'(bus_if.ready), 1);
        bus_if.ADDRESS = 16'h0100;
        exp_q.push_back(8'h5A);
        bus_if.rd_n = 1'b0;
        repeat (4) @(negedge clk);
        bus_if.rd_n = 1'b1;
        @(negedge clk);
        read_cycle(16'h0100, IO_M_MEM, 1'b1, 8'hA3, low, seen_busy);

        // Reset while in RD_DRIVE.
        exp_q.push_back(8'h5A);
        start_cycle(16'h0105, IO_M_MEM);
        bus_if.rd_n = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_data_z",  32'(data_released),  1);
        check("midrst_busy",    32'(bus_if.busy),    0);
        check("midrst_ready",   32'(bus_if.ready),   1);
        check("midrst_bus_err", 32'(bus_if.bus_err), 0);
        rst         = 1'b1;
        bus_if.rd_n = 1'b1;
        @(negedge clk);
        read_cycle(16'h0105, IO_M_MEM, 1'b1, 8'h5A, low, seen_busy);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
